// File: rtl/bsg_comm_link_chan_remap.sv
// Runtime-programmable logical/physical channel remapper with staged, validated map commits
// and per-logical-channel calibration-pattern lock tracking.
module bsg_comm_link_chan_remap #(
   parameter int num_channels_p  = 4,
   parameter int channel_width_p = 8,
   parameter logic [num_channels_p*$clog2(num_channels_p)-1:0] default_map_p = 8'hE4,
   parameter logic [channel_width_p-1:0] calib_pattern_p = 8'hA5,
   parameter int calib_count_p   = 16
) (
   input  logic                                        clk_i,
   input  logic                                        async_reset_n_i,
   input  logic [num_channels_p-1:0]                   phys_v_i,
   input  logic [num_channels_p*channel_width_p-1:0]   phys_data_i,
   output logic [num_channels_p-1:0]                   log_v_o,
   output logic [num_channels_p*channel_width_p-1:0]   log_data_o,
   input  logic                                        map_v_i,
   input  logic [$clog2(num_channels_p)-1:0]           map_idx_i,
   input  logic [$clog2(num_channels_p)-1:0]           map_phys_i,
   input  logic                                        map_commit_i,
   output logic                                        map_ready_o,
   output logic                                        map_err_o,
   output logic [num_channels_p-1:0]                   calib_done_o,
   output logic                                        all_calib_done_o
);
   localparam int lg_n  = $clog2(num_channels_p);
   localparam int map_w = num_channels_p * lg_n;
   localparam int cnt_w = $clog2(calib_count_p + 1);
   localparam logic [cnt_w-1:0] cnt_max = cnt_w'(calib_count_p);

   typedef enum logic [1:0] {ST_ACTIVE = 2'd0, ST_STAGE = 2'd1, ST_CHECK = 2'd2} state_t;

   function automatic logic f_is_perm(input logic [map_w-1:0] m);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < num_channels_p; i++) begin
         ok = ok & (int'(m[i*lg_n +: lg_n]) < num_channels_p);
         for (int j = i + 1; j < num_channels_p; j++) begin
            ok = ok & (m[i*lg_n +: lg_n] != m[j*lg_n +: lg_n]);
         end
      end
      return ok;
   endfunction

   if (num_channels_p < 2 || calib_count_p < 1 || !f_is_perm(default_map_p)) begin : g_bad_params
      $error("bsg_comm_link_chan_remap: illegal parameters or default_map_p is not a permutation");
   end

   state_t                                     r_state, w_next_state;
   logic [map_w-1:0]                           r_active, r_staged;
   logic                                       r_err;
   logic [num_channels_p-1:0]                  r_log_v, r_done;
   logic [num_channels_p*channel_width_p-1:0]  r_log_data;
   logic [cnt_w-1:0]                           r_cnt [num_channels_p];
   logic [cnt_w-1:0]                           w_cnt_inc [num_channels_p];
   logic [num_channels_p-1:0]                  w_map_v;
   logic [num_channels_p*channel_width_p-1:0]  w_map_data;
   logic                                       w_ready, w_legal, w_commit_ok;

   assign w_ready     = (r_state != ST_CHECK);
   assign w_legal     = f_is_perm(r_staged);
   assign w_commit_ok = (r_state == ST_CHECK) && w_legal;

   // Config FSM state register
   always_ff @(posedge clk_i or negedge async_reset_n_i) begin
      if (!async_reset_n_i) r_state <= ST_ACTIVE;
      else                  r_state <= w_next_state;
   end

   // Config FSM next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_ACTIVE: begin
            if (map_commit_i)  w_next_state = ST_CHECK;
            else if (map_v_i)  w_next_state = ST_STAGE;
            else               w_next_state = ST_ACTIVE;
         end
         ST_STAGE: begin
            if (map_commit_i)  w_next_state = ST_CHECK;
            else               w_next_state = ST_STAGE;
         end
         ST_CHECK: w_next_state = ST_ACTIVE;
         default:  w_next_state = ST_ACTIVE;
      endcase
   end

   // Active/staged maps and sticky commit error; a same-cycle write lands before the check
   always_ff @(posedge clk_i or negedge async_reset_n_i) begin
      if (!async_reset_n_i) begin
         r_active <= default_map_p;
         r_staged <= default_map_p;
         r_err    <= 1'b0;
      end else if (r_state == ST_CHECK) begin
         if (w_legal) begin
            r_active <= r_staged;
            r_err    <= 1'b0;
         end else begin
            r_staged <= r_active;
            r_err    <= 1'b1;
         end
      end else if (map_v_i) begin
         r_staged[int'(map_idx_i)*lg_n +: lg_n] <= map_phys_i;
      end
   end

   // Mapped physical inputs and saturating counter increments per logical channel
   always_comb begin
      w_map_v    = '0;
      w_map_data = '0;
      for (int l = 0; l < num_channels_p; l++) begin
         w_map_v[l] = phys_v_i[r_active[l*lg_n +: lg_n]];
         w_map_data[l*channel_width_p +: channel_width_p] =
            phys_data_i[int'(r_active[l*lg_n +: lg_n])*channel_width_p +: channel_width_p];
         w_cnt_inc[l] = (r_cnt[l] == cnt_max) ? r_cnt[l] : r_cnt[l] + cnt_w'(1);
      end
   end

   // Registered datapath, captured regardless of valid
   always_ff @(posedge clk_i or negedge async_reset_n_i) begin
      if (!async_reset_n_i) begin
         r_log_v    <= '0;
         r_log_data <= '0;
      end else begin
         r_log_v    <= w_map_v;
         r_log_data <= w_map_data;
      end
   end

   // Calibration lock tracking; a successful commit restarts every channel
   always_ff @(posedge clk_i or negedge async_reset_n_i) begin
      if (!async_reset_n_i) begin
         for (int l = 0; l < num_channels_p; l++) r_cnt[l] <= '0;
         r_done <= '0;
      end else if (w_commit_ok) begin
         for (int l = 0; l < num_channels_p; l++) r_cnt[l] <= '0;
         r_done <= '0;
      end else begin
         for (int l = 0; l < num_channels_p; l++) begin
            if (!w_map_v[l]) begin
               r_cnt[l] <= r_cnt[l];
            end else if (w_map_data[l*channel_width_p +: channel_width_p] == calib_pattern_p) begin
               r_cnt[l]  <= w_cnt_inc[l];
               r_done[l] <= r_done[l] | (w_cnt_inc[l] == cnt_max);
            end else begin
               r_cnt[l] <= r_done[l] ? r_cnt[l] : '0;
            end
         end
      end
   end

   assign log_v_o          = r_log_v;
   assign log_data_o       = r_log_data;
   assign map_ready_o      = w_ready;
   assign map_err_o        = r_err;
   assign calib_done_o     = r_done;
   assign all_calib_done_o = &r_done;

endmodule

// File: doc/bsg_comm_link_chan_remap.md
# bsg_comm_link_chan_remap

Parametrised, runtime-programmable channel remapper and calibration monitor that sits between the physical comm-link channel group and the core. It replaces the fixed per-board channel swizzle with a map loaded through a small config port. Changes are staged and only committed if the new map is a legal permutation. It also tracks per-channel calibration-pattern lock and drives a "calibration done" status suitable for a borrowed status pin.

## Interface
- num_channels_p, 4, channel count N (≥2); lg_n = clog2(N)
- channel_width_p, 8, data bits W per channel
- default_map_p, 8'hE4 (identity for N=4), reset map; entry l at bits [l*lg_n +: lg_n] names the physical source of logical channel l; must be a permutation (elaboration assertion)
- calib_pattern_p, 'hA5, W-bit calibration word
- calib_count_p, 16, consecutive pattern words needed for lock (≥1)

Ports:
- clk_i  in  1  sole clock
- async_reset_n_i  in  1  asynchronous, active-low reset
- phys_v_i  in  N  per-physical-channel valid
- phys_data_i  in  N*W  physical channel data, channel p at [p*W +: W]
- log_v_o  out  N  per-logical-channel valid, registered
- log_data_o  out  N*W  logical channel data, registered
- map_v_i  in  1  write one staged map entry
- map_idx_i  in  lg_n  logical index being written
- map_phys_i  in  lg_n  physical source for that index
- map_commit_i  in  1  request to apply staged map
- map_ready_o  out  1  config port accepts map_v_i / map_commit_i
- map_err_o  out  1  last commit rejected (sticky)
- calib_done_o  out  N  per-logical-channel calibration lock (sticky)
- all_calib_done_o  out  1  AND of calib_done_o

## Operation
- Two map registers: active (drives datapath) and staged (config writes). Outside a pending change, staged == active.
- FSM states:
  - ACTIVE: map_ready_o=1; map_v_i writes staged[map_idx_i] and moves to STAGE.
  - STAGE: map_ready_o=1; further writes allowed.
  - CHECK: map_ready_o=0.
- Transitions:
  - map_commit_i in ACTIVE or STAGE moves to CHECK.
  - map_v_i and map_commit_i in the same cycle: the write lands first and is included in the check.
  - CHECK lasts exactly one cycle, then returns to ACTIVE.
  - Legal map (every entry < N, all entries distinct): active <= staged, map_err_o <= 0, all calib counters and calib_done_o cleared.
  - Illegal map: staged <= active, map_err_o <= 1, active map and calib state untouched.
- Inputs while map_ready_o=0 are ignored.
- Datapath, every cycle, for each logical l with s = active[l]:
  - log_v_o[l] <= phys_v_i[s]
  - log_data_o[l] <= phys_data_i[s]
  - data is captured even when not valid
- Calibration, per logical l, using the same mapped inputs:
  - valid and data == calib_pattern_p: counter increments, saturating at calib_count_p.
  - valid with any other data: counter cleared, unless done is already set.
  - not valid: counter holds.
  - calib_done_o[l] sets on the edge that loads the counter with calib_count_p.
  - calib_done_o[l] clears only on reset or on a successful commit.
- all_calib_done_o is the combinational AND of the registered done flags.

## Timing
- Reset (async assert, sync release by the integrator):
  - log_v_o=0, log_data_o=0, calib_done_o=0, all_calib_done_o=0, map_err_o=0, map_ready_o=1
  - active and staged maps = default_map_p; FSM in ACTIVE; counters 0
  - reset during STAGE or CHECK discards the staged map
- Datapath latency is 1 cycle, with no bubbles. A successful commit in CHECK at edge k affects inputs sampled at edge k+1 onward.
- Calibration lock timing:
  - calib_done_o rises in the same cycle the calib_count_p-th consecutive matching word appears on log_data_o.
  - With calib_count_p=1, a single matching word locks.
- Commit response: map_commit_i high at edge k gives map_ready_o=0 during cycle k..k+1. Map and error update at edge k+1; map_ready_o=1 from then.

## Test plan
- Reset, then phys_data_i={8'h44,8'h33,8'h22,8'h11}, all valid -> after 1 cycle log_data_o identical; all outputs at the listed reset values before that.
- Write map 0→3,1→1,2→2,3→0, commit -> map_ready_o low exactly 1 cycle, map_err_o=0; same input then yields log_data_o={8'h11,8'h33,8'h22,8'h44}.
- Write entries 0→1 and 1→1, commit -> map_err_o=1, datapath mapping unchanged, a further map_v_i edit starts from the active map; a next legal commit clears map_err_o.
- Channel 2 sends 15 A5 words, one 5A word, then 16 A5 words -> calib_done_o[2] rises only on the 32nd word's output cycle; all_calib_done_o=1 once all 4 are locked; a later 5A word leaves it set.
- Channel locked, then a legal commit -> calib_done_o and all_calib_done_o drop to 0 the cycle after CHECK; relock needs calib_count_p fresh matches; invalid cycles interleaved do not break the count.
- map_v_i and map_commit_i in the same cycle; async_reset_n_i asserted mid-CHECK -> the simultaneous write is included in the commit; reset leaves the default map active and map_err_o=0.
